iccm_ctrl: RTL and testbench
============================

Name: iccm_ctrl

Overview:
- Responder side of the core's instruction-fetch interface. Sits between rv_top's fetch port and the DFFRAM instruction memory macro.
- Accepts fetch requests with a req/gnt handshake and returns read data with rvalid/rready.
- Arbitrates a program-loader write port into the same memory, so hex images are loaded by hardware rather than by backdoor.
- Owns address range checking and response buffering.

Parameters:
DEPTH, 256, memory size in 32-bit words; address index ADDR_W = $clog2(DEPTH)
BOOT_LOAD, 1, 1: leave reset in LOAD state; 0: leave reset in RUN state
ERR_RDATA, 32'h0000_0000, rdata returned with an error response

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
fetch_req_i  in  1  core fetch request
fetch_addr_i  in  32  byte address
fetch_gnt_o  out  1  request accepted this cycle (combinational)
fetch_rvalid_o  out  1  response valid
fetch_rready_i  in  1  core accepts response
fetch_rdata_o  out  32  instruction word
fetch_err_o  out  1  response is an error (out of range or misaligned)
load_valid_i  in  1  loader write valid
load_addr_i  in  ADDR_W  word index
load_data_i  in  32  write data
load_be_i  in  4  byte enables
load_ready_o  out  1  loader write accepted this cycle
load_done_i  in  1  loader finished (single-cycle pulse)
mem_en_o  out  1  DFFRAM EN
mem_we_o  out  4  DFFRAM WE
mem_a_o  out  ADDR_W  DFFRAM A
mem_di_o  out  32  DFFRAM Di
mem_do_i  in  32  DFFRAM Do; valid one cycle after EN with WE=0
perf_fetch_o  out  32  granted fetch count (see Optional Feature)
perf_stall_o  out  32  stall cycle count (see Optional Feature)

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- On reset:
  - state = LOAD if BOOT_LOAD, else RUN.
  - Response slot empty, fetch_rvalid_o=0, fetch_err_o=0, fetch_rdata_o=0.
  - mem_en_o=0, mem_we_o=0.
  - Perf counters = 0.
- States:
  - LOAD:
    - fetch_gnt_o=0; load_ready_o=1.
    - load_done_i moves the state to RUN on the next cycle. A write presented in the same cycle is still performed.
  - RUN:
    - Fetch has priority. load_ready_o = !fetch_req_i.
    - load_done_i is ignored.
    - There is no path back to LOAD except reset.
- Grant rule:
  - gnt = RUN && fetch_req_i && (slot empty || (fetch_rvalid_o && fetch_rready_i)).
  - At most one response is outstanding.
  - Back-to-back grants give 1 fetch/cycle while rready is held high.
- Granted legal fetch:
  - Legal means addr[1:0]==0 and addr[31:2] < DEPTH.
  - mem_en_o=1, mem_we_o=0, mem_a_o=addr[ADDR_W+1:2].
  - fetch_rvalid_o=1 next cycle with rdata=mem_do_i and err=0. Latency is 1 cycle.
- Granted illegal fetch:
  - No memory access.
  - rvalid next cycle with err=1 and rdata=ERR_RDATA.
- Backpressure:
  - If rready=0 while rvalid=1, rdata/err are captured into the hold register.
  - rvalid, rdata and err stay stable until rready=1. Later mem_do_i changes must not corrupt the held data.
- Loader write accepted (load_valid_i && load_ready_o):
  - mem_en_o=1, mem_we_o=load_be_i, mem_a_o=load_addr_i, mem_di_o=load_data_i.
  - Zero response, no effect on the fetch path.
- Idle cycles: mem_en_o=0, mem_we_o=0.
- Reset mid-response discards the pending response; no rvalid follows reset.
- A fetch after a write to the same word returns the new data.

Optional Feature:
- Macro ICCM_PERF_CNT_EN.
- Defined:
  - perf_fetch_o increments on every grant.
  - perf_stall_o increments on each RUN cycle with fetch_req_i=1 and gnt=0.
  - Both counters saturate at 32'hFFFF_FFFF.
- Undefined: both outputs are tied to 0 and no counter flops are generated.

Decomposition:
- Package iccm_pkg holds:
  - state enum iccm_state_e {ICCM_LOAD, ICCM_RUN}
  - ICCM_DEPTH_DEFAULT
  - ICCM_ERR_RDATA_DEFAULT
  - response struct iccm_rsp_t {rdata, err}
- Sub-module iccm_rsp_buf: 1-entry skid buffer, taking the memory/err input, producing rvalid/rdata/err output, with a ready input.

Test Plan:
- BOOT_LOAD=1; load words 0..3 with 32'h00000013, 32'h00100093, 32'h00200113, 32'h00300193, then pulse load_done_i. Fetch 0x0,0x4,0x8,0xC with rready=1 -> four grants on consecutive cycles, rvalid each following cycle, data in order, err=0.
- In LOAD, fetch_req_i=1 for 5 cycles -> gnt=0 throughout, no rvalid; perf_stall_o stays 0.
- RUN, fetch 0x4 with rready=0 for 3 cycles -> rvalid high, rdata=32'h00100093 stable, second request not granted until the cycle rready=1.
- Fetch 0x402 (misaligned) and 0x400 (DEPTH=256, out of range) -> rvalid with err=1, rdata=ERR_RDATA, mem_en_o=0 on the grant cycle.
- RUN, fetch_req_i and load_valid_i together -> fetch granted, load_ready_o=0. Next idle cycle the write to word 1 with be=4'b0011, data 32'hDEADBEEF is accepted. A later fetch 0x4 returns 32'h0010BEEF.
- Assert rst_ni=0 one cycle after a grant -> no rvalid, state returns to LOAD; with ICCM_PERF_CNT_EN the counters read 0.

Source files
------------

// File: rtl/iccm_pkg.sv
// Shared types and defaults for the instruction closely-coupled memory controller.
package iccm_pkg;

    typedef enum logic {
        ICCM_LOAD = 1'b0,
        ICCM_RUN  = 1'b1
    } iccm_state_e;

    localparam int          ICCM_DEPTH_DEFAULT     = 256;
    localparam logic [31:0] ICCM_ERR_RDATA_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } iccm_rsp_t;

    function automatic logic [31:0] iccm_sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/iccm_rsp_buf.sv
// Single-entry fetch response slot. Read data is passed through from the memory
// on the first response cycle and captured into the hold register under backpressure.
module iccm_rsp_buf
    import iccm_pkg::*;
#(
    parameter logic [31:0] ERR_RDATA = ICCM_ERR_RDATA_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_push,
    input  logic        i_push_err,
    input  logic [31:0] i_mem_do,
    input  logic        i_ready,
    output logic        o_can_push,
    output logic        o_valid,
    output logic [31:0] o_rdata,
    output logic        o_err
);

    logic      r_valid;
    logic      r_live;
    iccm_rsp_t r_hold;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_live  <= 1'b0;
            r_hold  <= '0;
        end else if (i_push) begin
            r_valid    <= 1'b1;
            r_live     <= !i_push_err;
            r_hold.err <= i_push_err;
            if (i_push_err) begin
                r_hold.rdata <= ERR_RDATA;
            end
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end else if (r_valid && r_live) begin
            // Memory output is only guaranteed for one cycle after the read.
            r_hold.rdata <= i_mem_do;
            r_live       <= 1'b0;
        end
    end

    assign o_can_push = !r_valid || i_ready;
    assign o_valid    = r_valid;
    assign o_rdata    = r_live ? i_mem_do : r_hold.rdata;
    assign o_err      = r_hold.err;

endmodule

// File: rtl/iccm_ctrl.sv
// Instruction-fetch responder in front of the DFFRAM macro, with a program-loader
// write port. Optional perf counters are enabled by defining ICCM_PERF_CNT_EN.
module iccm_ctrl
    import iccm_pkg::*;
#(
    parameter int          DEPTH     = ICCM_DEPTH_DEFAULT,
    parameter int          ADDR_W    = $clog2(DEPTH),
    parameter bit          BOOT_LOAD = 1'b1,
    parameter logic [31:0] ERR_RDATA = ICCM_ERR_RDATA_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              fetch_req_i,
    input  logic [31:0]       fetch_addr_i,
    output logic              fetch_gnt_o,
    output logic              fetch_rvalid_o,
    input  logic              fetch_rready_i,
    output logic [31:0]       fetch_rdata_o,
    output logic              fetch_err_o,
    input  logic              load_valid_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic [31:0]       load_data_i,
    input  logic [3:0]        load_be_i,
    output logic              load_ready_o,
    input  logic              load_done_i,
    output logic              mem_en_o,
    output logic [3:0]        mem_we_o,
    output logic [ADDR_W-1:0] mem_a_o,
    output logic [31:0]       mem_di_o,
    input  logic [31:0]       mem_do_i,
    output logic [31:0]       perf_fetch_o,
    output logic [31:0]       perf_stall_o
);

    iccm_state_e r_state;
    iccm_state_e w_state_nxt;
    logic        w_run;
    logic        w_legal;
    logic        w_can_push;
    logic        w_gnt;
    logic        w_load_ready;

    assign w_run   = (r_state == ICCM_RUN);
    assign w_legal = (fetch_addr_i[1:0] == 2'b00) &&
                     ({2'b00, fetch_addr_i[31:2]} < 32'(DEPTH));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= BOOT_LOAD ? ICCM_LOAD : ICCM_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_gnt        = 1'b0;
        w_load_ready = 1'b0;
        mem_en_o     = 1'b0;
        mem_we_o     = 4'b0000;
        mem_a_o      = '0;
        mem_di_o     = '0;
        case (r_state)
            ICCM_LOAD: begin
                w_load_ready = 1'b1;
                if (load_done_i) begin
                    w_state_nxt = ICCM_RUN;
                end
            end
            ICCM_RUN: begin
                w_gnt        = fetch_req_i && w_can_push;
                w_load_ready = !fetch_req_i;
            end
            default: w_state_nxt = r_state;
        endcase
        // Fetch and loader never collide: the loader is held off while a fetch is requested.
        if (w_gnt && w_legal) begin
            mem_en_o = 1'b1;
            mem_a_o  = fetch_addr_i[ADDR_W+1:2];
        end else if (load_valid_i && w_load_ready) begin
            mem_en_o = 1'b1;
            mem_we_o = load_be_i;
            mem_a_o  = load_addr_i;
            mem_di_o = load_data_i;
        end
    end

    assign fetch_gnt_o  = w_gnt;
    assign load_ready_o = w_load_ready;

    iccm_rsp_buf #(
        .ERR_RDATA (ERR_RDATA)
    ) u_rsp_buf (
        .i_clk      (clk_i),
        .i_rst_n    (rst_ni),
        .i_push     (w_gnt),
        .i_push_err (!w_legal),
        .i_mem_do   (mem_do_i),
        .i_ready    (fetch_rready_i),
        .o_can_push (w_can_push),
        .o_valid    (fetch_rvalid_o),
        .o_rdata    (fetch_rdata_o),
        .o_err      (fetch_err_o)
    );

`ifdef ICCM_PERF_CNT_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_perf_fetch <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_gnt) begin
                r_perf_fetch <= iccm_sat_inc(r_perf_fetch);
            end
            if (w_run && fetch_req_i && !w_gnt) begin
                r_perf_stall <= iccm_sat_inc(r_perf_stall);
            end
        end
    end

    assign perf_fetch_o = r_perf_fetch;
    assign perf_stall_o = r_perf_stall;
`else
    assign perf_fetch_o = '0;
    assign perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_iccm_ctrl.sv
// Bench for iccm_ctrl: DFFRAM model, fetch response scoreboard and scenario tasks.
module tb_iccm_ctrl;

    localparam int DEPTH  = 256;
    localparam int ADDR_W = 8;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_rsp_t;

    logic              clk_i;
    logic              rst_ni;
    logic              fetch_req_i;
    logic [31:0]       fetch_addr_i;
    logic              fetch_gnt_o;
    logic              fetch_rvalid_o;
    logic              fetch_rready_i;
    logic [31:0]       fetch_rdata_o;
    logic              fetch_err_o;
    logic              load_valid_i;
    logic [ADDR_W-1:0] load_addr_i;
    logic [31:0]       load_data_i;
    logic [3:0]        load_be_i;
    logic              load_ready_o;
    logic              load_done_i;
    logic              mem_en_o;
    logic [3:0]        mem_we_o;
    logic [ADDR_W-1:0] mem_a_o;
    logic [31:0]       mem_di_o;
    logic [31:0]       mem_do_i;
    logic [31:0]       perf_fetch_o;
    logic [31:0]       perf_stall_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] tb_mem  [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    exp_rsp_t    sb_q [$];

    iccm_ctrl #(
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .BOOT_LOAD (1'b1),
        .ERR_RDATA (32'h0000_0000)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .fetch_req_i    (fetch_req_i),
        .fetch_addr_i   (fetch_addr_i),
        .fetch_gnt_o    (fetch_gnt_o),
        .fetch_rvalid_o (fetch_rvalid_o),
        .fetch_rready_i (fetch_rready_i),
        .fetch_rdata_o  (fetch_rdata_o),
        .fetch_err_o    (fetch_err_o),
        .load_valid_i   (load_valid_i),
        .load_addr_i    (load_addr_i),
        .load_data_i    (load_data_i),
        .load_be_i      (load_be_i),
        .load_ready_o   (load_ready_o),
        .load_done_i    (load_done_i),
        .mem_en_o       (mem_en_o),
        .mem_we_o       (mem_we_o),
        .mem_a_o        (mem_a_o),
        .mem_di_o       (mem_di_o),
        .mem_do_i       (mem_do_i),
        .perf_fetch_o   (perf_fetch_o),
        .perf_stall_o   (perf_stall_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // DFFRAM model: Do is only meaningful the cycle after a read, garbage otherwise.
    always @(posedge clk_i) begin
        if (mem_en_o && mem_we_o == 4'b0000) begin
            mem_do_i <= tb_mem[mem_a_o];
        end else begin
            if (mem_en_o) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_we_o[b]) tb_mem[mem_a_o][b*8 +: 8] <= mem_di_o[b*8 +: 8];
                end
            end
            mem_do_i <= $urandom;
        end
    end

    function automatic exp_rsp_t model_rsp(input logic [31:0] addr);
        exp_rsp_t r;
        if (addr[1:0] != 2'b00 || addr[31:2] >= 30'(DEPTH)) begin
            r.rdata = 32'h0000_0000;
            r.err   = 1'b1;
        end else begin
            r.rdata = ref_mem[addr[ADDR_W+1:2]];
            r.err   = 1'b0;
        end
        return r;
    endfunction

    // Scoreboard: push on grant, pop on accepted response.
    always @(negedge clk_i) begin : sb_mon
        exp_rsp_t e;
        if (!rst_ni) begin
            sb_q.delete();
        end else begin
            if (fetch_rvalid_o && fetch_rready_i) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected_rsp: got rdata=%h err=%b with nothing outstanding",
                             fetch_rdata_o, fetch_err_o);
                end else begin
                    e = sb_q.pop_front();
                    if (fetch_rdata_o !== e.rdata || fetch_err_o !== e.err) begin
                        n_fail++;
                        $display("FAIL sb_rsp: got rdata=%h err=%b want rdata=%h err=%b",
                                 fetch_rdata_o, fetch_err_o, e.rdata, e.err);
                    end
                end
            end
            if (fetch_gnt_o) sb_q.push_back(model_rsp(fetch_addr_i));
        end
    end

    task automatic next_cycle;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset;
        rst_ni = 1'b0;
        fetch_req_i = 1'b1; fetch_addr_i = 32'h0; fetch_rready_i = 1'b1;
        load_valid_i = 1'b0; load_addr_i = '0; load_data_i = '0; load_be_i = '0; load_done_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #3;
        n_checks++; if (fetch_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid: got %b want 0", fetch_rvalid_o); end
        n_checks++; if (fetch_err_o !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", fetch_err_o); end
        n_checks++; if (fetch_rdata_o !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", fetch_rdata_o); end
        n_checks++; if (fetch_gnt_o !== 1'b0) begin n_fail++; $display("FAIL rst_gnt: got %b want 0", fetch_gnt_o); end
        n_checks++; if (mem_en_o !== 1'b0 || mem_we_o !== 4'b0) begin n_fail++; $display("FAIL rst_mem: got en=%b we=%b want 0/0", mem_en_o, mem_we_o); end
        n_checks++; if (load_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_load_ready: got %b want 1", load_ready_o); end
        n_checks++; if (perf_fetch_o !== 32'h0 || perf_stall_o !== 32'h0) begin n_fail++; $display("FAIL rst_perf: got %0d/%0d want 0/0", perf_fetch_o, perf_stall_o); end
        fetch_req_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        next_cycle();
    endtask

    task automatic test_load_gating;
        fetch_req_i = 1'b1; fetch_addr_i = 32'h0;
        for (int i = 0; i < 5; i++) begin
            #3;
            n_checks++; if (fetch_gnt_o !== 1'b0) begin n_fail++; $display("FAIL load_gate_gnt%0d: got %b want 0", i, fetch_gnt_o); end
            n_checks++; if (fetch_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL load_gate_rvalid%0d: got %b want 0", i, fetch_rvalid_o); end
            next_cycle();
        end
        fetch_req_i = 1'b0;
        #3;
        n_checks++; if (perf_stall_o !== 32'h0) begin n_fail++; $display("FAIL load_gate_stall: got %0d want 0", perf_stall_o); end
        next_cycle();
    endtask

    task automatic test_load_image;
        logic [31:0] img [4];
        img[0] = 32'h0000_0013; img[1] = 32'h0010_0093;
        img[2] = 32'h0020_0113; img[3] = 32'h0030_0193;
        for (int i = 0; i < 4; i++) begin
            load_valid_i = 1'b1; load_addr_i = ADDR_W'(i); load_data_i = img[i]; load_be_i = 4'hF;
            #3;
            n_checks++; if (load_ready_o !== 1'b1) begin n_fail++; $display("FAIL load_ready%0d: got %b want 1", i, load_ready_o); end
            n_checks++;
            if (mem_en_o !== 1'b1 || mem_we_o !== 4'hF || mem_a_o !== ADDR_W'(i) || mem_di_o !== img[i]) begin
                n_fail++;
                $display("FAIL load_wr%0d: got en=%b we=%h a=%0d di=%h want 1/f/%0d/%h",
                         i, mem_en_o, mem_we_o, mem_a_o, mem_di_o, i, img[i]);
            end
            ref_mem[i] = img[i];
            next_cycle();
        end
        load_valid_i = 1'b0; load_done_i = 1'b1;
        next_cycle();
        load_done_i = 1'b0;
        #3;
        n_checks++; if (mem_en_o !== 1'b0 || mem_we_o !== 4'b0) begin n_fail++; $display("FAIL idle_mem: got en=%b we=%b want 0/0", mem_en_o, mem_we_o); end
        next_cycle();
    endtask

    task automatic test_back_to_back;
        fetch_rready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            fetch_req_i  = (i < 4);
            fetch_addr_i = 32'(i * 4);
            #3;
            if (i < 4) begin
                n_checks++; if (fetch_gnt_o !== 1'b1) begin n_fail++; $display("FAIL b2b_gnt%0d: got %b want 1", i, fetch_gnt_o); end
                n_checks++; if (mem_en_o !== 1'b1 || mem_a_o !== ADDR_W'(i)) begin n_fail++; $display("FAIL b2b_mem%0d: got en=%b a=%0d want 1/%0d", i, mem_en_o, mem_a_o, i); end
            end
            if (i > 0) begin
                n_checks++; if (fetch_rvalid_o !== 1'b1) begin n_fail++; $display("FAIL b2b_rvalid%0d: got %b want 1", i, fetch_rvalid_o); end
            end
            next_cycle();
        end
        #3;
        n_checks++; if (fetch_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got rvalid=%b want 0", fetch_rvalid_o); end
        next_cycle();
    endtask

    task automatic test_backpressure;
        fetch_rready_i = 1'b0; fetch_req_i = 1'b1; fetch_addr_i = 32'h4;
        #3;
        n_checks++; if (fetch_gnt_o !== 1'b1) begin n_fail++; $display("FAIL bp_first_gnt: got %b want 1", fetch_gnt_o); end
        next_cycle();
        fetch_addr_i = 32'h0;
        for (int i = 0; i < 3; i++) begin
            #3;
            n_checks++; if (fetch_gnt_o !== 1'b0) begin n_fail++; $display("FAIL bp_gnt%0d: got %b want 0", i, fetch_gnt_o); end
            n_checks++;
            if (fetch_rvalid_o !== 1'b1 || fetch_rdata_o !== 32'h0010_0093 || fetch_err_o !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got v=%b d=%h e=%b want 1/00100093/0", i, fetch_rvalid_o, fetch_rdata_o, fetch_err_o);
            end
            next_cycle();
        end
        fetch_rready_i = 1'b1;
        #3;
        n_checks++; if (fetch_gnt_o !== 1'b1) begin n_fail++; $display("FAIL bp_release_gnt: got %b want 1", fetch_gnt_o); end
        n_checks++; if (fetch_rdata_o !== 32'h0010_0093) begin n_fail++; $display("FAIL bp_release_data: got %h want 00100093", fetch_rdata_o); end
        next_cycle();
        fetch_req_i = 1'b0;
        #3;
        n_checks++; if (fetch_rvalid_o !== 1'b1 || fetch_rdata_o !== 32'h0000_0013) begin n_fail++; $display("FAIL bp_second: got v=%b d=%h want 1/00000013", fetch_rvalid_o, fetch_rdata_o); end
        next_cycle();
    endtask

    task automatic test_illegal;
        logic [31:0] addrs [2];
        addrs[0] = 32'h402; addrs[1] = 32'h400;
        fetch_rready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fetch_req_i = (i < 2);
            if (i < 2) fetch_addr_i = addrs[i];
            #3;
            if (i < 2) begin
                n_checks++; if (fetch_gnt_o !== 1'b1) begin n_fail++; $display("FAIL ill_gnt%0d: got %b want 1", i, fetch_gnt_o); end
                n_checks++; if (mem_en_o !== 1'b0) begin n_fail++; $display("FAIL ill_mem_en%0d: got %b want 0", i, mem_en_o); end
            end
            if (i > 0) begin
                n_checks++;
                if (fetch_rvalid_o !== 1'b1 || fetch_err_o !== 1'b1 || fetch_rdata_o !== 32'h0) begin
                    n_fail++;
                    $display("FAIL ill_rsp%0d: got v=%b e=%b d=%h want 1/1/00000000", i, fetch_rvalid_o, fetch_err_o, fetch_rdata_o);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_fetch_load_conflict;
        fetch_rready_i = 1'b1; fetch_req_i = 1'b1; fetch_addr_i = 32'h0;
        load_valid_i = 1'b1; load_addr_i = 8'd1; load_data_i = 32'hDEAD_BEEF; load_be_i = 4'b0011;
        #3;
        n_checks++; if (fetch_gnt_o !== 1'b1) begin n_fail++; $display("FAIL conf_gnt: got %b want 1", fetch_gnt_o); end
        n_checks++; if (load_ready_o !== 1'b0) begin n_fail++; $display("FAIL conf_load_ready: got %b want 0", load_ready_o); end
        n_checks++; if (mem_we_o !== 4'b0000) begin n_fail++; $display("FAIL conf_we: got %b want 0000", mem_we_o); end
        next_cycle();
        fetch_req_i = 1'b0;
        #3;
        n_checks++; if (load_ready_o !== 1'b1) begin n_fail++; $display("FAIL conf_load_ready2: got %b want 1", load_ready_o); end
        n_checks++;
        if (mem_en_o !== 1'b1 || mem_we_o !== 4'b0011 || mem_a_o !== 8'd1 || mem_di_o !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL conf_wr: got en=%b we=%b a=%0d di=%h want 1/0011/1/deadbeef", mem_en_o, mem_we_o, mem_a_o, mem_di_o);
        end
        next_cycle();
        ref_mem[1] = {ref_mem[1][31:16], 16'hBEEF};
        load_valid_i = 1'b0; fetch_req_i = 1'b1; fetch_addr_i = 32'h4;
        #3;
        n_checks++; if (fetch_gnt_o !== 1'b1) begin n_fail++; $display("FAIL conf_refetch_gnt: got %b want 1", fetch_gnt_o); end
        next_cycle();
        fetch_req_i = 1'b0;
        #3;
        n_checks++; if (fetch_rdata_o !== 32'h0010_BEEF) begin n_fail++; $display("FAIL conf_new_data: got %h want 0010beef", fetch_rdata_o); end
        next_cycle();
    endtask

    task automatic test_reset_mid;
        #3;
`ifdef ICCM_PERF_CNT_EN
        n_checks++; if (perf_fetch_o !== 32'd10 || perf_stall_o !== 32'd3) begin n_fail++; $display("FAIL perf_totals: got %0d/%0d want 10/3", perf_fetch_o, perf_stall_o); end
`else
        n_checks++; if (perf_fetch_o !== 32'd0 || perf_stall_o !== 32'd0) begin n_fail++; $display("FAIL perf_tied: got %0d/%0d want 0/0", perf_fetch_o, perf_stall_o); end
`endif
        next_cycle();
        fetch_rready_i = 1'b0; fetch_req_i = 1'b1; fetch_addr_i = 32'h0;
        #3;
        n_checks++; if (fetch_gnt_o !== 1'b1) begin n_fail++; $display("FAIL rmid_gnt: got %b want 1", fetch_gnt_o); end
        next_cycle();
        rst_ni = 1'b0; fetch_req_i = 1'b0;
        #2;
        n_checks++; if (fetch_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL rmid_rvalid: got %b want 0", fetch_rvalid_o); end
        n_checks++; if (perf_fetch_o !== 32'h0 || perf_stall_o !== 32'h0) begin n_fail++; $display("FAIL rmid_perf: got %0d/%0d want 0/0", perf_fetch_o, perf_stall_o); end
        next_cycle();
        rst_ni = 1'b1; fetch_rready_i = 1'b1; fetch_req_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #3;
            n_checks++; if (fetch_gnt_o !== 1'b0 || load_ready_o !== 1'b1) begin n_fail++; $display("FAIL rmid_load_state%0d: got gnt=%b lr=%b want 0/1", i, fetch_gnt_o, load_ready_o); end
            n_checks++; if (fetch_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL rmid_no_rsp%0d: got %b want 0", i, fetch_rvalid_o); end
            next_cycle();
        end
        fetch_req_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            tb_mem[i]  = 32'h0;
            ref_mem[i] = 32'h0;
        end
        test_reset();
        test_load_gating();
        test_load_image();
        test_back_to_back();
        test_backpressure();
        test_illegal();
        test_fetch_load_conflict();
        test_reset_mid();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_outstanding: got %0d pending responses want 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
